clk_div_ratio_meas: RTL and testbench

//  Decoder side of the integer clock divider. It samples the divider's clock-enable strobe (i_clk_ref domain) and recovers the effective divide ratio.
//  - Counts i_clk_ref cycles between consecutive strobes.
//  - Compares each period against the expected ratio; declares lock after LOCK_CNT consecutive matches.
//  - Flags a missing strobe as a timeout.

---
 rtl/clk_div_ratio_meas.sv | 150 +++++++++++++++
 tb/tb_clk_div_ratio_meas.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ratio_meas.sv
// Recovers the effective divide ratio of an integer clock divider from its enable strobe,
// with lock tracking and timeout. Optional sticky irq flag: define CLK_DIV_MEAS_IRQ_EN.
module clk_div_ratio_meas #(
  parameter int DIV_NUM_WD = 4,
  parameter int LOCK_CNT   = 4
) (
  input  logic                  i_clk_ref,
  input  logic                  i_rst_n,
  input  logic                  i_meas_en,
  input  logic                  i_clk_en,
  input  logic [DIV_NUM_WD-1:0] i_exp_div_num,
  input  logic                  i_irq_clr,
  output logic [DIV_NUM_WD-1:0] o_div_num_meas,
  output logic                  o_meas_vld,
  output logic                  o_mismatch,
  output logic                  o_timeout,
  output logic                  o_lock,
  output logic                  o_irq
);

  localparam int CNT_WD  = DIV_NUM_WD + 1;
  localparam int LCNT_WD = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_WD-1:0]  CNT_ONE     = CNT_WD'(1);
  localparam logic [CNT_WD-1:0]  CNT_TIMEOUT = CNT_WD'(1) << DIV_NUM_WD;
  localparam logic [LCNT_WD-1:0] LCNT_MAX    = LCNT_WD'(LOCK_CNT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  // NOTE: reset is asserted asynchronously but released through two flops so every
  // downstream flop leaves reset on the same clock edge, free of recovery/removal hazards.
  logic [1:0] rst_sync_q;
  logic       rst_sync_n;

  always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[1];

  logic [1:0]            state;
  logic [CNT_WD-1:0]     cnt;
  logic [LCNT_WD-1:0]    lock_cnt;
  logic [DIV_NUM_WD-1:0] exp_eff;
  logic                  period_match;
  logic                  cnt_at_timeout;
  logic [LCNT_WD-1:0]    lock_cnt_inc;

  // A programmed ratio of 0 means "divide by 1".
  assign exp_eff        = (i_exp_div_num == '0) ? DIV_NUM_WD'(1) : i_exp_div_num;
  assign period_match   = (cnt == {1'b0, exp_eff});
  assign cnt_at_timeout = (cnt == CNT_TIMEOUT);
  assign lock_cnt_inc   = (lock_cnt == LCNT_MAX) ? LCNT_MAX : lock_cnt + LCNT_WD'(1);

  // NOTE: every register below uses non-blocking assignment so all of them update
  // together from the values sampled at the same edge.
  always_ff @(posedge i_clk_ref or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      lock_cnt       <= '0;
      o_div_num_meas <= '0;
      o_meas_vld     <= 1'b0;
      o_mismatch     <= 1'b0;
      o_timeout      <= 1'b0;
      o_lock         <= 1'b0;
    end else begin
      o_meas_vld <= 1'b0;
      o_mismatch <= 1'b0;
      o_timeout  <= 1'b0;

      if (!i_meas_en) begin
        // Disable wins over everything; the last measurement stays visible.
        state    <= ST_IDLE;
        cnt      <= '0;
        lock_cnt <= '0;
        o_lock   <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ARM;
          end

          ST_ARM: begin
            if (i_clk_en) begin
              cnt   <= CNT_ONE;
              state <= ST_RUN;
            end
          end

          ST_RUN: begin
            if (i_clk_en) begin
              // A strobe at cnt == 2^DIV_NUM_WD beats the timeout and reports 0.
              o_div_num_meas <= cnt[DIV_NUM_WD-1:0];
              o_meas_vld     <= 1'b1;
              o_mismatch     <= !period_match;
              cnt            <= CNT_ONE;
              if (period_match) begin
                lock_cnt <= lock_cnt_inc;
                if (lock_cnt_inc == LCNT_MAX) begin
                  o_lock <= 1'b1;
                end
              end else begin
                lock_cnt <= '0;
                o_lock   <= 1'b0;
              end
            end else if (cnt_at_timeout) begin
              o_timeout <= 1'b1;
              o_lock    <= 1'b0;
              lock_cnt  <= '0;
              cnt       <= '0;
              state     <= ST_ARM;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef CLK_DIV_MEAS_IRQ_EN
  // Sticky error flag: a new error pulse outranks a clear in the same cycle.
  always_ff @(posedge i_clk_ref or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      o_irq <= 1'b0;
    end else if (o_mismatch || o_timeout) begin
      o_irq <= 1'b1;
    end else if (i_irq_clr) begin
      o_irq <= 1'b0;
    end
  end
`else
  logic unused_irq_clr;

  assign unused_irq_clr = i_irq_clr;
  assign o_irq          = 1'b0;
`endif

endmodule

// File: tb/tb_clk_div_ratio_meas.sv
// Bench for clk_div_ratio_meas: directed table and corner sequences plus random strobe
// traffic, all compared against a period-arithmetic reference model.
module tb_clk_div_ratio_meas;

  localparam int W    = 4;
  localparam int LOCK = 4;
  localparam int WRAP = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         meas_en;
  logic         clk_en;
  logic [W-1:0] exp_div;
  logic         irq_clr;
  logic [W-1:0] o_div_num_meas;
  logic         o_meas_vld;
  logic         o_mismatch;
  logic         o_timeout;
  logic         o_lock;
  logic         o_irq;

  always #5 clk = ~clk;

  clk_div_ratio_meas #(.DIV_NUM_WD(W), .LOCK_CNT(LOCK)) dut (
    .i_clk_ref      (clk),
    .i_rst_n        (rst_n),
    .i_meas_en      (meas_en),
    .i_clk_en       (clk_en),
    .i_exp_div_num  (exp_div),
    .i_irq_clr      (irq_clr),
    .o_div_num_meas (o_div_num_meas),
    .o_meas_vld     (o_meas_vld),
    .o_mismatch     (o_mismatch),
    .o_timeout      (o_timeout),
    .o_lock         (o_lock),
    .o_irq          (o_irq)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Reference model: tracks the cycle index of the last aligned strobe and derives
  // every measurement as a difference of cycle indices.
  int           m_cyc;
  int           m_rel;
  int           m_last;
  int           m_streak;
  bit           m_active;
  bit           m_aligned;
  bit           m_lock;
  bit           m_vld;
  bit           m_mm;
  bit           m_to;
  bit           m_irq;
  logic [W-1:0] m_meas;

  task automatic model_reset();
    m_rel     = 0;
    m_last    = 0;
    m_streak  = 0;
    m_active  = 0;
    m_aligned = 0;
    m_lock    = 0;
    m_vld     = 0;
    m_mm      = 0;
    m_to      = 0;
    m_irq     = 0;
    m_meas    = '0;
  endtask

  task automatic model_edge();
    int per;
    int eff;
    m_cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    // Two edges pass while the reset release crosses the synchroniser.
    if (m_rel < 2) begin
      m_rel++;
      return;
    end
`ifdef CLK_DIV_MEAS_IRQ_EN
    if (m_mm || m_to) m_irq = 1'b1;
    else if (irq_clr) m_irq = 1'b0;
`endif
    m_vld = 0;
    m_mm  = 0;
    m_to  = 0;
    if (!meas_en) begin
      m_active  = 0;
      m_aligned = 0;
      m_lock    = 0;
      m_streak  = 0;
    end else if (!m_active) begin
      m_active = 1;
    end else if (!m_aligned) begin
      if (clk_en) begin
        m_aligned = 1;
        m_last    = m_cyc;
      end
    end else begin
      per = m_cyc - m_last;
      if (clk_en) begin
        eff    = (exp_div == 0) ? 1 : int'(exp_div);
        m_meas = W'(per);
        m_vld  = 1;
        m_mm   = (per != eff);
        if (m_mm) begin
          m_streak = 0;
          m_lock   = 0;
        end else begin
          if (m_streak < LOCK) m_streak++;
          m_lock = (m_streak == LOCK);
        end
        m_last = m_cyc;
      end else if (per == WRAP) begin
        m_to      = 1;
        m_lock    = 0;
        m_streak  = 0;
        m_aligned = 0;
      end
    end
  endtask

  task automatic check_all();
    check("meas", o_div_num_meas, m_meas);
    check("vld", o_meas_vld, m_vld);
    check("mismatch", o_mismatch, m_mm);
    check("timeout", o_timeout, m_to);
    check("lock", o_lock, m_lock);
    check("irq", o_irq, m_irq);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cyc(input bit en, input bit stb, input int ex, input bit clr = 1'b0);
    meas_en = en;
    clk_en  = stb;
    exp_div = W'(ex);
    irq_clr = clr;
    step();
  endtask

  // p-1 quiet cycles then one strobe; outputs afterwards show that strobe's result.
  task automatic period(input int p, input int ex);
    for (int k = 1; k < p; k++) cyc(1'b1, 1'b0, ex);
    cyc(1'b1, 1'b1, ex);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_meas"}, o_div_num_meas, 0);
    check({tag, "_vld"}, o_meas_vld, 0);
    check({tag, "_mm"}, o_mismatch, 0);
    check({tag, "_to"}, o_timeout, 0);
    check({tag, "_lock"}, o_lock, 0);
    check({tag, "_irq"}, o_irq, 0);
  endtask

  typedef struct {
    bit en;
    bit stb;
    int ex;
    bit vld;
    bit mm;
    int meas;
    bit lock;
    bit to;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int per;
    int cd;
    int ex;
    bit en_r;
    bit stb_r;

    // Ratio 4 with a strobe every 4 cycles, starting from IDLE.
    for (int i = 0; i < 18; i++) begin
      tbl[i].en   = 1'b1;
      tbl[i].stb  = (i % 4 == 1);
      tbl[i].ex   = 4;
      tbl[i].vld  = (i >= 5) && (i % 4 == 1);
      tbl[i].mm   = 1'b0;
      tbl[i].meas = (i >= 5) ? 4 : 0;
      tbl[i].lock = (i >= 17);
      tbl[i].to   = 1'b0;
    end

    m_cyc = 0;
    model_reset();
    rst_n   = 1'b0;
    meas_en = 1'b0;
    clk_en  = 1'b0;
    exp_div = '0;
    irq_clr = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(1, 0, 4);
    cyc(1, 0, 4);

    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].en, tbl[i].stb, tbl[i].ex);
      check("t1_vld", o_meas_vld, tbl[i].vld);
      check("t1_mm", o_mismatch, tbl[i].mm);
      check("t1_meas", o_div_num_meas, tbl[i].meas);
      check("t1_lock", o_lock, tbl[i].lock);
      check("t1_to", o_timeout, tbl[i].to);
    end

    // Enable drop while locked: lock clears, measurement holds.
    cyc(0, 0, 4);
    check("endrop_lock", o_lock, 0);
    check("endrop_meas", o_div_num_meas, 4);
    check("endrop_vld", o_meas_vld, 0);

    // Bypass: exp 0 treated as 1, strobe held high.
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    check("byp_arm_vld", o_meas_vld, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0);
      check("byp_vld", o_meas_vld, 1);
      check("byp_meas", o_div_num_meas, 1);
      check("byp_lock", o_lock, (i == 3));
    end

    // Expected 5, actual 6: mismatch on every result, never locks.
    for (int i = 0; i < 4; i++) begin
      period(6, 5);
      check("r6_meas", o_div_num_meas, 6);
      check("r6_mm", o_mismatch, 1);
      check("r6_lock", o_lock, 0);
    end
    for (int i = 0; i < 4; i++) begin
      period(5, 5);
      check("r5_meas", o_div_num_meas, 5);
      check("r5_mm", o_mismatch, 0);
      check("r5_lock", o_lock, (i == 3));
    end

    // Locked at 3, then strobes stop.
    for (int i = 0; i < 4; i++) period(3, 3);
    check("r3_lock", o_lock, 1);
    k = 1;
    while (k <= 40) begin
      cyc(1, 0, 3);
      if (o_timeout) break;
      k++;
    end
    check("timeout_delay", k, 16);
    check("timeout_lock", o_lock, 0);
    check("timeout_meas", o_div_num_meas, 3);
    cyc(1, 1, 3);
    check("rearm_vld", o_meas_vld, 0);
    period(3, 3);
    check("rearm_vld2", o_meas_vld, 1);
    check("rearm_meas", o_div_num_meas, 3);

    // Strobe exactly at the timeout count reads back as 0 and is a mismatch.
    period(16, 15);
    check("wrap_vld", o_meas_vld, 1);
    check("wrap_meas", o_div_num_meas, 0);
    check("wrap_mm", o_mismatch, 1);
    check("wrap_to", o_timeout, 0);
    period(15, 15);
    check("max_meas", o_div_num_meas, 15);
    check("max_mm", o_mismatch, 0);

    // Reset in the middle of RUN.
    period(2, 2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    cyc(1, 1, 2);
    rst_n = 1'b1;
    cyc(1, 1, 2);
    check_all_zero("rst_hold1");
    cyc(1, 1, 2);
    check_all_zero("rst_hold2");

`ifdef CLK_DIV_MEAS_IRQ_EN
    cyc(1, 0, 5, 1);
    check("irq_idle", o_irq, 0);
    cyc(1, 1, 5);
    period(2, 5);
    check("irq_mm_pulse", o_mismatch, 1);
    cyc(1, 0, 5);
    check("irq_set", o_irq, 1);
    cyc(1, 0, 5, 1);
    check("irq_clr", o_irq, 0);
    k = 1;
    while (k <= 40) begin
      cyc(1, 0, 5);
      if (o_timeout) break;
      k++;
    end
    check("irq_to_seen", o_timeout, 1);
    check("irq_before_set", o_irq, 0);
    cyc(1, 0, 5, 1);
    check("irq_set_beats_clr", o_irq, 1);
`endif

    // Random traffic: period and expected ratio change every 50 cycles.
    per = 4;
    ex  = 4;
    cd  = 0;
    for (int n = 0; n < 3000; n++) begin
      if (n % 50 == 0) begin
        per = $urandom_range(1, 18);
        ex  = ($urandom_range(0, 1) == 1) ? per : int'($urandom_range(0, 15));
      end
      en_r = ($urandom_range(0, 99) >= 2);
      if (cd <= 1) begin
        stb_r = 1'b1;
        cd    = per;
      end else begin
        stb_r = ($urandom_range(0, 99) == 0);
        cd--;
      end
      cyc(en_r, stb_r, ex, ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
